instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage of the 32-bit pipelined CPU.
- Holds the program counter (PC) and drives it to instruction memory.
- Each cycle, selects the next PC from one of:
  - sequential PC+4
  - predicted branch target
  - branch-undo (mispredict recovery) address
  - register-jump target
  - interrupt vector / interrupt-return address
- Owns interrupt entry (one-level, maskable) and the saved-PC (EPC) register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- INT_VECTOR, 32'h0000_0100, PC loaded on interrupt entry.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1).
- alert  input  1  external interrupt request, level-sampled each cycle.
- stall  input  1  hold PC (pipeline stall).
- branch_predict  input  1  predicted-taken branch; load branch_pc.
- pcr_take  input  1  register jump; load pcr.
- pci_take  input  1  interrupt return; load EPC and clear mask.
- branch_undo  input  1  mispredict recovery; load pc_not_taken.
- branch_pc  input  32  predicted branch target.
- pc_not_taken  input  32  fall-through address for recovery.
- pcr  input  32  register-jump target.
- mem_addr  output  32  current PC, to instruction memory.
- pc_plus_4  output  32  current PC + 4.
- interrupt  output  1  one-cycle pulse on interrupt entry.
- interrupt_mask  output  1  interrupts masked (in handler).

Behaviour:
- State: PC (32b), EPC (32b), mask (1b), interrupt flag (1b); optional pending flag.
- Reset (rst_n=1 at edge):
  - PC=RESET_PC, EPC=0, mask=0, interrupt=0.
  - Overrides all other inputs.
- mem_addr = PC, direct from register (no combinational path from inputs).
- pc_plus_4 = PC + 32'd4, combinational, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- No alignment check: targets are loaded verbatim, low bits included.
- Next-PC priority per edge, highest first:
  1. Interrupt take, when alert=1 and mask=0: PC=INT_VECTOR, EPC=current PC, mask=1, interrupt=1 next cycle.
  2. branch_undo: PC=pc_not_taken.
  3. stall: PC holds.
  4. pcr_take: PC=pcr.
  5. pci_take: PC=EPC, mask=0.
  6. branch_predict: PC=branch_pc.
  7. Otherwise: PC=PC+4.
- Consequences of the priority order:
  - stall suppresses pcr_take, pci_take and branch_predict.
  - Interrupt and branch_undo override stall.
- Any selection other than an interrupt take leaves EPC unchanged.
- interrupt:
  - Registered; high exactly one cycle, the cycle PC first equals INT_VECTOR.
  - Re-asserts only after mask clears and alert is seen again.
- Interrupt_mask:
  - Set on interrupt take; cleared only by an accepted pci_take or by reset.
  - alert while mask=1 is ignored (see optional feature).
- pci_take while mask=0 is legal: PC=EPC (0 after reset), mask stays 0.
- Reset mid-handler: mask and EPC cleared, PC=RESET_PC.

Optional Feature:
- Macro IF_PENDING_IRQ_EN.
- Defined:
  - alert seen while mask=1 sets a pending flag.
  - Pending is taken as an interrupt the first cycle mask=0 (alert need not still be high).
  - Pending clears when taken or on reset.
- Undefined: no pending flag; alert while masked is dropped.

Test Plan:
- Reset held, then released: mem_addr=0 during reset; then 0,4,8,12 on successive cycles; pc_plus_4 = mem_addr+4.
- stall=1 for 2 cycles at PC=16: mem_addr stays 16, then resumes 20.
- branch_predict=1, branch_pc=10: next mem_addr=10. pcr_take=1, pcr=30: next mem_addr=30. branch_undo with pc_not_taken=20 plus stall=1: mem_addr=20 (undo beats stall).
- alert=1 one cycle at PC=P, mask=0: next mem_addr=0x100, interrupt=1 for one cycle, interrupt_mask=1; later pci_take=1 -> mem_addr=P, interrupt_mask=0.
- alert while mask=1:
  - Undefined IF_PENDING_IRQ_EN: no interrupt.
  - Defined: interrupt fires the cycle after the pci_take returns.
- PC=0xFFFF_FFFC, no control: pc_plus_4=0, next mem_addr=0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: pipeline control and targets in, PC and interrupt status out.
// master = pipeline/control side, slave = the instr_fetch stage.
interface instr_fetch_if;
  logic        alert;
  logic        stall;
  logic        branch_predict;
  logic        pcr_take;
  logic        pci_take;
  logic        branch_undo;
  logic [31:0] branch_pc;
  logic [31:0] pc_not_taken;
  logic [31:0] pcr;
  logic [31:0] mem_addr;
  logic [31:0] pc_plus_4;
  logic        interrupt;
  logic        interrupt_mask;

  modport master (
    output alert, stall, branch_predict, pcr_take, pci_take, branch_undo,
    output branch_pc, pc_not_taken, pcr,
    input  mem_addr, pc_plus_4, interrupt, interrupt_mask
  );

  modport slave (
    input  alert, stall, branch_predict, pcr_take, pci_take, branch_undo,
    input  branch_pc, pc_not_taken, pcr,
    output mem_addr, pc_plus_4, interrupt, interrupt_mask
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, one-level maskable interrupt with EPC.
// Optional macro IF_PENDING_IRQ_EN latches alerts seen while masked and takes them once unmasked.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0100
) (
  input logic          clk,
  input logic          rst_n,   // synchronous, active-high despite the name
  instr_fetch_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        mask_q, mask_d;
  logic        irq_q;
  logic        irq_take;

`ifdef IF_PENDING_IRQ_EN
  logic pend_q;

  assign irq_take = !mask_q && (bus.alert || pend_q);

  always_ff @(posedge clk) begin
    if (rst_n)
      pend_q <= 1'b0;
    else if (irq_take)
      pend_q <= 1'b0;
    else if (mask_q && bus.alert)
      pend_q <= 1'b1;
  end
`else
  assign irq_take = !mask_q && bus.alert;
`endif

  // Priority chain: interrupt, undo, stall, register jump, interrupt return, prediction, sequential.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    pc_d   = pc_q + 32'd4;
    epc_d  = epc_q;
    mask_d = mask_q;
    if (irq_take) begin
      pc_d   = INT_VECTOR;
      epc_d  = pc_q;
      mask_d = 1'b1;
    end else if (bus.branch_undo) begin
      pc_d = bus.pc_not_taken;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.pcr_take) begin
      pc_d = bus.pcr;
    end else if (bus.pci_take) begin
      pc_d   = epc_q;
      mask_d = 1'b0;
    end else if (bus.branch_predict) begin
      pc_d = bus.branch_pc;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_n) begin
      pc_q   <= RESET_PC;
      epc_q  <= 32'h0000_0000;
      mask_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      mask_q <= mask_d;
      irq_q  <= irq_take;
    end
  end

  assign bus.mem_addr       = pc_q;
  assign bus.pc_plus_4      = pc_q + 32'd4;
  assign bus.interrupt      = irq_q;
  assign bus.interrupt_mask = mask_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, sequencing, stall, jumps, interrupt entry/return, wrap.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_if fif ();

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .INT_VECTOR (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc,
                             input logic irq, input logic mask);
    check({tag, ".mem_addr"},  fif.mem_addr, pc);
    check({tag, ".pc_plus_4"}, fif.pc_plus_4, pc + 32'd4);
    check({tag, ".interrupt"}, {31'd0, fif.interrupt}, {31'd0, irq});
    check({tag, ".mask"},      {31'd0, fif.interrupt_mask}, {31'd0, mask});
  endtask

  initial begin
    rst_n              = 1'b1;
    fif.alert          = 1'b0;
    fif.stall          = 1'b0;
    fif.branch_predict = 1'b0;
    fif.pcr_take       = 1'b0;
    fif.pci_take       = 1'b0;
    fif.branch_undo    = 1'b0;
    fif.branch_pc      = 32'h0;
    fif.pc_not_taken   = 32'h0;
    fif.pcr            = 32'h0;

    step();
    step();
    check_state("reset", 32'h0, 1'b0, 1'b0);

    // Release reset: sequential fetch 0,4,8,12,16
    rst_n = 1'b0;
    check_state("rel0", 32'h0, 1'b0, 1'b0);
    step(); check_state("seq4",  32'd4,  1'b0, 1'b0);
    step(); check_state("seq8",  32'd8,  1'b0, 1'b0);
    step(); check_state("seq12", 32'd12, 1'b0, 1'b0);
    step(); check_state("seq16", 32'd16, 1'b0, 1'b0);

    // Two-cycle stall at 16
    fif.stall = 1'b1;
    step(); check_state("stall1", 32'd16, 1'b0, 1'b0);
    step(); check_state("stall2", 32'd16, 1'b0, 1'b0);
    fif.stall = 1'b0;
    step(); check_state("resume", 32'd20, 1'b0, 1'b0);

    // Predicted branch, register jump, undo beating stall
    fif.branch_predict = 1'b1; fif.branch_pc = 32'd10;
    step(); check_state("bpred", 32'd10, 1'b0, 1'b0);
    fif.branch_predict = 1'b0;
    fif.pcr_take = 1'b1; fif.pcr = 32'd30;
    step(); check_state("pcr", 32'd30, 1'b0, 1'b0);
    fif.pcr_take = 1'b0;
    fif.branch_undo = 1'b1; fif.pc_not_taken = 32'd20; fif.stall = 1'b1;
    step(); check_state("undo_stall", 32'd20, 1'b0, 1'b0);
    fif.branch_undo = 1'b0;
    // Stall suppresses a register jump
    fif.pcr_take = 1'b1; fif.pcr = 32'h500;
    step(); check_state("stall_pcr", 32'd20, 1'b0, 1'b0);
    fif.pcr_take = 1'b0; fif.stall = 1'b0;
    step(); check_state("seq24", 32'd24, 1'b0, 1'b0);

    // Interrupt at P=24
    fif.alert = 1'b1;
    step(); check_state("irq_take", 32'h100, 1'b1, 1'b1);
    fif.alert = 1'b0;
    step(); check_state("irq_pulse_end", 32'h104, 1'b0, 1'b1);

    // Alert while masked
    fif.alert = 1'b1;
    step(); check_state("masked_alert", 32'h108, 1'b0, 1'b1);
    fif.alert = 1'b0;
    fif.pci_take = 1'b1;
    step(); check_state("pci_ret", 32'd24, 1'b0, 1'b0);
    fif.pci_take = 1'b0;
`ifdef IF_PENDING_IRQ_EN
    step(); check_state("pend_take", 32'h100, 1'b1, 1'b1);
    fif.pci_take = 1'b1;
    step(); check_state("pend_ret", 32'd24, 1'b0, 1'b0);
    fif.pci_take = 1'b0;
    step(); check_state("after_pend", 32'd28, 1'b0, 1'b0);
`else
    step(); check_state("dropped_alert", 32'd28, 1'b0, 1'b0);
`endif

    // Interrupt beats undo and stall at PC=28
    fif.alert = 1'b1; fif.stall = 1'b1;
    fif.branch_undo = 1'b1; fif.pc_not_taken = 32'h40;
    step(); check_state("irq_over_undo", 32'h100, 1'b1, 1'b1);
    fif.alert = 1'b0; fif.branch_undo = 1'b0;
    // Stall suppresses interrupt return
    fif.pci_take = 1'b1;
    step(); check_state("stall_pci", 32'h100, 1'b0, 1'b1);
    fif.stall = 1'b0;
    step(); check_state("pci_ret2", 32'd28, 1'b0, 1'b0);
    fif.pci_take = 1'b0;

    // Reset mid-handler clears mask and EPC
    fif.alert = 1'b1;
    step(); check_state("irq_take3", 32'h100, 1'b1, 1'b1);
    fif.alert = 1'b0;
    rst_n = 1'b1;
    step(); check_state("reset_mid", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(); check_state("post_reset", 32'd4, 1'b0, 1'b0);
    // Unmasked interrupt return loads the cleared EPC
    fif.pci_take = 1'b1;
    step(); check_state("pci_unmasked", 32'h0, 1'b0, 1'b0);
    fif.pci_take = 1'b0;

    // Wraparound at the top of the address space
    fif.branch_predict = 1'b1; fif.branch_pc = 32'hFFFF_FFFC;
    step();
    check("wrap.mem_addr",  fif.mem_addr,  32'hFFFF_FFFC);
    check("wrap.pc_plus_4", fif.pc_plus_4, 32'h0000_0000);
    fif.branch_predict = 1'b0;
    step(); check_state("wrapped", 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
